// File: rtl/mem_access_ctrl_if.sv
// Requester and memory-port signal bundle for mem_access_ctrl.
// slave: the controller side; master: requesters plus memory.
interface mem_access_ctrl_if;
    logic        if_req_valid;
    logic        if_req_ready;
    logic        if_req_we;
    logic [31:0] if_req_addr;
    logic [31:0] if_req_wdata;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_rdata;
    logic        if_rsp_err;

    logic        dm_req_valid;
    logic        dm_req_ready;
    logic        dm_req_we;
    logic [31:0] dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_rdata;
    logic        dm_rsp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_write_select;
    logic [31:0] mem_rdata;
    logic        busy;

    modport slave (
        input  if_req_valid, if_req_we, if_req_addr, if_req_wdata,
        output if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
        input  dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata,
        output dm_req_ready, dm_rsp_valid, dm_rsp_rdata, dm_rsp_err,
        output mem_addr, mem_wdata, mem_write_select, busy,
        input  mem_rdata
    );

    modport master (
        output if_req_valid, if_req_we, if_req_addr, if_req_wdata,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
        output dm_req_valid, dm_req_we, dm_req_addr, dm_req_wdata,
        input  dm_req_ready, dm_rsp_valid, dm_rsp_rdata, dm_rsp_err,
        input  mem_addr, mem_wdata, mem_write_select, busy,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Round-robin arbiter and sequencer for the shared instruction/data memory port.
// Optional access counters enabled by defining MEM_ACCESS_CTRL_PERF_EN.
module mem_access_ctrl #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned DEPTH        = 4096
) (
    input  logic clk,
    input  logic rst,
    mem_access_ctrl_if.slave bus
`ifdef MEM_ACCESS_CTRL_PERF_EN
    ,
    output logic [31:0] perf_if_count,
    output logic [31:0] perf_dm_count,
    output logic [31:0] perf_err_count
`endif
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_src;
    logic        r_we;
    logic        r_err;
    logic        r_prefer_dm;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [2:0]  r_cnt;

    logic        w_grant_dm;
    logic        w_grant_if;
    logic        w_accept;
    logic        w_req_we;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_wdata;
    logic        w_req_oor;
    logic        w_last;

    // Grant only goes to a port that is requesting; the pointer breaks ties.
    always_comb begin
        w_grant_dm  = bus.dm_req_valid && (!bus.if_req_valid || r_prefer_dm);
        w_grant_if  = bus.if_req_valid && !w_grant_dm;
        w_accept    = (r_state == IDLE) && (w_grant_dm || w_grant_if);
        w_req_we    = w_grant_dm ? bus.dm_req_we    : bus.if_req_we;
        w_req_addr  = w_grant_dm ? bus.dm_req_addr  : bus.if_req_addr;
        w_req_wdata = w_grant_dm ? bus.dm_req_wdata : bus.if_req_wdata;
        w_req_oor   = (w_req_addr >= 32'(DEPTH));
        w_last      = (r_cnt == 3'(READ_LATENCY - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_req_oor ? RESP : ACCESS;
            ACCESS:  if (w_last) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src       <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_prefer_dm <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_src       <= w_grant_dm;
                        r_we        <= w_req_we;
                        r_addr      <= w_req_addr;
                        r_wdata     <= w_req_wdata;
                        r_err       <= w_req_oor;
                        r_rdata     <= '0;
                        r_cnt       <= '0;
                        r_prefer_dm <= !w_grant_dm;
                    end
                end
                ACCESS: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last && !r_we) r_rdata <= bus.mem_rdata;
                end
                default: ;
            endcase
        end
    end

    // Write strobe only in the first ACCESS cycle; address/data held for the whole window.
    always_comb begin
        bus.if_req_ready     = (r_state == IDLE) && w_grant_if;
        bus.dm_req_ready     = (r_state == IDLE) && w_grant_dm;
        bus.if_rsp_valid     = 1'b0;
        bus.if_rsp_rdata     = '0;
        bus.if_rsp_err       = 1'b0;
        bus.dm_rsp_valid     = 1'b0;
        bus.dm_rsp_rdata     = '0;
        bus.dm_rsp_err       = 1'b0;
        bus.mem_addr         = '0;
        bus.mem_wdata        = '0;
        bus.mem_write_select = 2'd2;
        bus.busy             = (r_state != IDLE);
        case (r_state)
            ACCESS: begin
                bus.mem_addr = r_addr;
                if (r_we) begin
                    bus.mem_wdata = r_wdata;
                    if (r_cnt == '0) bus.mem_write_select = {1'b0, r_src};
                end
            end
            RESP: begin
                if (r_src) begin
                    bus.dm_rsp_valid = 1'b1;
                    bus.dm_rsp_rdata = r_rdata;
                    bus.dm_rsp_err   = r_err;
                end else begin
                    bus.if_rsp_valid = 1'b1;
                    bus.if_rsp_rdata = r_rdata;
                    bus.if_rsp_err   = r_err;
                end
            end
            default: ;
        endcase
    end

`ifdef MEM_ACCESS_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_count  <= '0;
            perf_dm_count  <= '0;
            perf_err_count <= '0;
        end else if (w_accept) begin
            if (w_grant_if && perf_if_count != '1) perf_if_count <= perf_if_count + 32'd1;
            if (w_grant_dm && perf_dm_count != '1) perf_dm_count <= perf_dm_count + 32'd1;
            if (w_req_oor && perf_err_count != '1) perf_err_count <= perf_err_count + 32'd1;
        end
    end
`endif

endmodule
